// File: rtl/ce361_pipe_pkg.sv
// Shared definitions for the CE361 pipeline front end.
//   NOP              : instruction word placed in IF/ID on a bubble or flush
//   DEFAULT_RESET_PC : boot address that the fetch stage loads on reset
//   fetch_state_e    : fetch FSM encodings; 2'b11 is never produced
package ce361_pipe_pkg;

  localparam logic [31:0] NOP              = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_HOLD  = 2'b01,
    ST_FLUSH = 2'b10
  } fetch_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter. It counts up by one on each enabled edge and stops at all-ones.
//   clk   : rising-edge clock
//   reset : asynchronous active-high clear
//   en    : increment enable
//   count : current value
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (en && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage. It holds the PC and the IF/ID pipeline register.
// At each edge it applies one of these actions, in priority order:
// reset > branch redirect > ID stall > IF stall > normal fetch.
//   clk, reset   : clock and asynchronous active-high reset
//   IFstall      : branch-in-flight stall. The PC holds and a NOP goes into IF/ID.
//   IDstall      : data-hazard stall. PC and IF/ID hold, and EX receives a bubble.
//   br_taken     : branch resolved taken in EX. The stage redirects to br_target.
//   br_target    : redirect address (word aligned by clearing bits [1:0])
//   imem_data    : instruction at imem_addr, read in the same cycle
//   imem_addr    : current PC
//   IDinstr      : IF/ID instruction
//   IDpc4        : PC+4 of the instruction in IDinstr
//   IDvalid      : IF/ID holds a real fetched instruction
//   EXbubble     : combinational request for ID/EX to load a NOP
//   fetch_state  : registered FSM state (RUN/HOLD/FLUSH)
//   if_bubbles   : saturating count of IF-stall bubbles
//   id_stalls    : saturating count of ID-stall cycles
module if_fetch_stage
  import ce361_pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             IFstall,
  input  logic             IDstall,
  input  logic             br_taken,
  input  logic [31:0]      br_target,
  input  logic [31:0]      imem_data,
  output logic [31:0]      imem_addr,
  output logic [31:0]      IDinstr,
  output logic [31:0]      IDpc4,
  output logic             IDvalid,
  output logic             EXbubble,
  output logic [1:0]       fetch_state,
  output logic [CNT_W-1:0] if_bubbles,
  output logic [CNT_W-1:0] id_stalls
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q;
  logic [31:0]  pc_plus4;
  logic         do_redirect;
  logic         do_id_hold;
  logic         do_if_bubble;
  logic         unused_target_lsbs;

  // Each action is decoded once from this edge's inputs. The same signals
  // drive the datapath, the FSM and the counters, so the three cannot
  // disagree about which action happened.
  assign do_redirect  = br_taken;
  assign do_id_hold   = IDstall & ~br_taken;
  assign do_if_bubble = IFstall & ~IDstall & ~br_taken;

  assign pc_plus4           = pc_q + 32'd4;  // wraps modulo 2^32
  assign unused_target_lsbs = ^br_target[1:0];

  assign imem_addr   = pc_q;
  assign EXbubble    = do_id_hold;
  assign fetch_state = state_q;

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // The next state depends only on the current inputs and never on state_q.
  // This is how the unused encoding 2'b11 returns to a legal state on the next edge.
  always_comb begin
    state_d = ST_RUN;
    if (do_redirect) begin
      state_d = ST_FLUSH;
    end else if (do_id_hold) begin
      state_d = ST_HOLD;
    end else if (do_if_bubble) begin
      state_d = ST_FLUSH;
    end
  end

  // PC and IF/ID register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      IDinstr <= NOP;
      IDpc4   <= 32'h0;
      IDvalid <= 1'b0;
    end else if (do_redirect) begin
      pc_q    <= {br_target[31:2], 2'b00};
      IDinstr <= NOP;
      IDvalid <= 1'b0;
    end else if (do_id_hold) begin
      // everything holds
    end else if (do_if_bubble) begin
      IDinstr <= NOP;
      IDvalid <= 1'b0;
    end else begin
      pc_q    <= pc_plus4;
      IDinstr <= imem_data;
      IDpc4   <= pc_plus4;
      IDvalid <= 1'b1;
    end
  end

  sat_counter #(.W(CNT_W)) u_if_bubbles (
    .clk   (clk),
    .reset (reset),
    .en    (do_if_bubble),
    .count (if_bubbles)
  );

  sat_counter #(.W(CNT_W)) u_id_stalls (
    .clk   (clk),
    .reset (reset),
    .en    (do_id_hold),
    .count (id_stalls)
  );

endmodule
